// File: rtl/l2_noc2_out_arbiter.sv
// NoC2 output arbiter for the L2 slice: round-robin between pipe1 and pipe2 msg2 producers,
// captures a whole message (header + up to two payload flits) and serializes it onto noc2.
module l2_noc2_out_arbiter #(
   parameter int FLIT_W      = 64,
   parameter int MAX_PAYLOAD = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p1_valid_i,
   output logic              p1_ready_o,
   input  logic [1:0]        p1_len_i,
   input  logic [FLIT_W-1:0] p1_hdr_i,
   input  logic [FLIT_W-1:0] p1_data0_i,
   input  logic [FLIT_W-1:0] p1_data1_i,
   input  logic              p2_valid_i,
   output logic              p2_ready_o,
   input  logic [1:0]        p2_len_i,
   input  logic [FLIT_W-1:0] p2_hdr_i,
   input  logic [FLIT_W-1:0] p2_data0_i,
   input  logic [FLIT_W-1:0] p2_data1_i,
   output logic              noc2_valid_o,
   input  logic              noc2_ready_i,
   output logic [FLIT_W-1:0] noc2_data_o,
   output logic              busy_o,
   output logic              last_grant_o
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SEND    = 2'd1;
   localparam logic [1:0] LEN_MAX = (MAX_PAYLOAD > 2) ? 2'd2 : 2'(MAX_PAYLOAD);

   function automatic logic [1:0] clamp_len(input logic [1:0] len);
      return (len > LEN_MAX) ? LEN_MAX : len;
   endfunction

   logic [1:0]        state_q;
   logic [1:0]        idx_q;
   logic [1:0]        len_p0;
   logic [FLIT_W-1:0] hdr_p0;
   logic [FLIT_W-1:0] d0_p0;
   logic [FLIT_W-1:0] d1_p0;
   logic              sel_p2;
   logic              take;
   logic              send;

   // Round-robin: on contention the requester that did not win last time is served.
   always_comb begin
      sel_p2     = p2_valid_i & (~p1_valid_i | ~last_grant_o);
      take       = (state_q == IDLE) & ~rst & (p1_valid_i | p2_valid_i);
      p1_ready_o = take & ~sel_p2;
      p2_ready_o = take & sel_p2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= 2'd0;
         len_p0       <= 2'd0;
         last_grant_o <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (take) begin
                  state_q      <= SEND;
                  idx_q        <= 2'd0;
                  len_p0       <= clamp_len(sel_p2 ? p2_len_i : p1_len_i);
                  last_grant_o <= sel_p2;
               end
            end
            SEND: begin
               if (noc2_ready_i) begin
                  if (idx_q >= len_p0) begin
                     state_q <= IDLE;
                     idx_q   <= 2'd0;
                  end else begin
                     idx_q <= idx_q + 2'd1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               idx_q   <= 2'd0;
            end
         endcase
      end
   end

   // Capture stage: message payload is only written on a handshake, so it holds through stalls.
   always_ff @(posedge clk) begin
      if (take) begin
         hdr_p0 <= sel_p2 ? p2_hdr_i   : p1_hdr_i;
         d0_p0  <= sel_p2 ? p2_data0_i : p1_data0_i;
         d1_p0  <= sel_p2 ? p2_data1_i : p1_data1_i;
      end
   end

   // Serialize stage: flit selected by index, forced to zero outside SEND.
   always_comb begin
      send         = (state_q == SEND);
      noc2_valid_o = send;
      busy_o       = send;
      noc2_data_o  = '0;
      if (send) begin
         case (idx_q)
            2'd0:    noc2_data_o = hdr_p0;
            2'd1:    noc2_data_o = d0_p0;
            default: noc2_data_o = d1_p0;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_noc2_out_arbiter.sv
// Table-driven bench for l2_noc2_out_arbiter plus a hand-written stalled-transfer sequence.
module tb_l2_noc2_out_arbiter;

   localparam int FLIT_W = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              p1_valid, p1_ready;
   logic [1:0]        p1_len;
   logic [FLIT_W-1:0] p1_hdr, p1_d0, p1_d1;
   logic              p2_valid, p2_ready;
   logic [1:0]        p2_len;
   logic [FLIT_W-1:0] p2_hdr, p2_d0, p2_d1;
   logic              noc2_valid, noc2_ready;
   logic [FLIT_W-1:0] noc2_data;
   logic              busy, last_grant;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   l2_noc2_out_arbiter #(.FLIT_W(FLIT_W), .MAX_PAYLOAD(2)) dut (
      .clk(clk), .rst(rst),
      .p1_valid_i(p1_valid), .p1_ready_o(p1_ready), .p1_len_i(p1_len),
      .p1_hdr_i(p1_hdr), .p1_data0_i(p1_d0), .p1_data1_i(p1_d1),
      .p2_valid_i(p2_valid), .p2_ready_o(p2_ready), .p2_len_i(p2_len),
      .p2_hdr_i(p2_hdr), .p2_data0_i(p2_d0), .p2_data1_i(p2_d1),
      .noc2_valid_o(noc2_valid), .noc2_ready_i(noc2_ready), .noc2_data_o(noc2_data),
      .busy_o(busy), .last_grant_o(last_grant)
   );

   typedef struct {
      logic              rst;
      logic              p1v;
      logic [1:0]        p1l;
      logic [FLIT_W-1:0] p1h;
      logic              p2v;
      logic [1:0]        p2l;
      logic [FLIT_W-1:0] p2h;
      logic              nrdy;
      logic [4:0]        exp_ctl;   // {p1_ready, p2_ready, noc2_valid, busy, last_grant}
      logic [FLIT_W-1:0] exp_d;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic r, input logic a_v, input logic [1:0] a_l, input logic [FLIT_W-1:0] a_h,
                               input logic b_v, input logic [1:0] b_l, input logic [FLIT_W-1:0] b_h, input logic nr,
                               input logic e1r, input logic e2r, input logic env, input logic [FLIT_W-1:0] ed,
                               input logic ebusy, input logic elg);
      vec_t v;
      v.rst = r; v.p1v = a_v; v.p1l = a_l; v.p1h = a_h;
      v.p2v = b_v; v.p2l = b_l; v.p2h = b_h; v.nrdy = nr;
      v.exp_ctl = {e1r, e2r, env, ebusy, elg};
      v.exp_d = ed;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst = v.rst;
      p1_valid = v.p1v; p1_len = v.p1l; p1_hdr = v.p1h; p1_d0 = v.p1h + 1; p1_d1 = v.p1h + 2;
      p2_valid = v.p2v; p2_len = v.p2l; p2_hdr = v.p2h; p2_d0 = v.p2h + 1; p2_d1 = v.p2h + 2;
      noc2_ready = v.nrdy;
   endtask

   task automatic check(input string name, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic [FLIT_W-1:0] got[3];
   int n;

   initial begin
      // reset
      vq.push_back(mk(1,1,0,0,      1,0,0,      1, 0,0,0,0,0,0));
      // p1 only, len=2
      vq.push_back(mk(0,1,2,'hA,    0,0,0,      1, 1,0,0,0,0,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,1,'hA,1,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,1,'hB,1,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,1,'hC,1,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,0,0,0,0));
      // both valid after reset, len=0: p2, p1, p2, p1
      vq.push_back(mk(1,0,0,0,      0,0,0,      1, 0,0,0,0,0,0));
      vq.push_back(mk(0,1,0,'h10,   1,0,'h20,   1, 0,1,0,0,0,0));
      vq.push_back(mk(0,1,0,'h10,   1,0,'h20,   1, 0,0,1,'h20,1,1));
      vq.push_back(mk(0,1,0,'h10,   1,0,'h20,   1, 1,0,0,0,0,1));
      vq.push_back(mk(0,1,0,'h10,   1,0,'h20,   1, 0,0,1,'h10,1,0));
      vq.push_back(mk(0,1,0,'h10,   1,0,'h20,   1, 0,1,0,0,0,0));
      vq.push_back(mk(0,1,0,'h10,   1,0,'h20,   1, 0,0,1,'h20,1,1));
      vq.push_back(mk(0,1,0,'h10,   1,0,'h20,   1, 1,0,0,0,0,1));
      vq.push_back(mk(0,1,0,'h10,   1,0,'h20,   1, 0,0,1,'h10,1,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,0,0,0,0));
      // p2 len=1 with noc2 stall; p1 (len=3) waits and is served next, clamped to 3 flits
      vq.push_back(mk(0,0,0,0,      1,1,'h30,   0, 0,1,0,0,0,0));
      vq.push_back(mk(0,1,3,'h40,   0,0,0,      0, 0,0,1,'h30,1,1));
      vq.push_back(mk(0,1,3,'h40,   0,0,0,      0, 0,0,1,'h30,1,1));
      vq.push_back(mk(0,1,3,'h40,   0,0,0,      0, 0,0,1,'h30,1,1));
      vq.push_back(mk(0,1,3,'h40,   0,0,0,      1, 0,0,1,'h30,1,1));
      vq.push_back(mk(0,1,3,'h40,   0,0,0,      1, 0,0,1,'h31,1,1));
      vq.push_back(mk(0,1,3,'h40,   0,0,0,      1, 1,0,0,0,0,1));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,1,'h40,1,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,1,'h41,1,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,1,'h42,1,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,0,0,0,0));
      // p1 inputs change during SEND
      vq.push_back(mk(0,1,0,'h1,    0,0,0,      1, 1,0,0,0,0,0));
      vq.push_back(mk(0,1,0,'h2,    0,0,0,      0, 0,0,1,'h1,1,0));
      vq.push_back(mk(0,1,0,'h2,    0,0,0,      1, 0,0,1,'h1,1,0));
      vq.push_back(mk(0,1,0,'h2,    0,0,0,      1, 1,0,0,0,0,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,1,'h2,1,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,0,0,0,0));
      // reset in the middle of a 3-flit message, then a normal capture
      vq.push_back(mk(0,0,0,0,      1,2,'h50,   1, 0,1,0,0,0,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,1,'h50,1,1));
      vq.push_back(mk(1,1,0,'h60,   0,0,0,      1, 0,0,1,'h51,1,1));
      vq.push_back(mk(0,1,0,'h60,   0,0,0,      1, 1,0,0,0,0,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,1,'h60,1,0));
      vq.push_back(mk(0,0,0,0,      0,0,0,      1, 0,0,0,0,0,0));

      drive(mk(1,0,0,0, 0,0,0, 0, 0,0,0,0,0,0));
      repeat (2) @(posedge clk);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i]);
         #1;
         checks++;
         if ({p1_ready, p2_ready, noc2_valid, busy, last_grant} !== vq[i].exp_ctl || noc2_data !== vq[i].exp_d) begin
            errors++;
            $display("FAIL vec%0d: got ctl=%b data=%h expected ctl=%b data=%h", i,
                     {p1_ready, p2_ready, noc2_valid, busy, last_grant}, noc2_data,
                     vq[i].exp_ctl, vq[i].exp_d);
         end
      end

      // p2 len=2 with noc2_ready toggling every cycle
      @(negedge clk);
      drive(mk(0,0,0,0, 1,2,'h70, 0, 0,0,0,0,0,0));
      #1;
      check("alt_grant_p2", {63'd0, p2_ready}, 64'd1);
      n = 0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         @(negedge clk);
         p2_valid = 1'b0;
         noc2_ready = (c % 2 == 1);
         #1;
         if (noc2_valid && noc2_ready) begin
            got[n] = noc2_data;
            n++;
         end
      end
      check("alt_flit_count", 64'(n), 64'd3);
      for (int k = 0; k < n; k++) check("alt_flit", got[k], 64'h70 + 64'(k));
      @(negedge clk);
      noc2_ready = 1'b0;
      #1;
      check("alt_busy_done", {62'd0, busy, noc2_valid}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
